crossing_reg_src: RTL
=====================

# crossing_reg_src

Source-domain controller that feeds a `CrossingRegN` holding register, and runs a toggle request/acknowledge handshake with the destination domain. It accepts a write from local logic, drives the crossing register's `D_IN`/`EN` for exactly one cycle, and then toggles a request line. It blocks further writes until the destination's acknowledge toggle, resynchronised locally, matches the request. This is the block directly upstream of every `CrossingRegN` instance used for a quasi-static control word.

## Interface
Parameters:
- `width`, 1, data width; must match the downstream `CrossingRegN`.
- `init`, `{width{1'b0}}`, reset value of `XD`; must match the downstream `init`.
- `sync_stages`, 2, number of acknowledge synchroniser flops; legal range 2..4.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  source-domain clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `D_IN`  in  width  write data from local logic.
- `EN`  in  1  write request; accepted when `EN && RDY` at a rising edge.
- `RDY`  out  1  write can be accepted this cycle.
- `XD`  out  width  registered data, to `CrossingRegN.D_IN`.
- `XEN`  out  1  registered one-cycle load strobe, to `CrossingRegN.EN`.
- `REQ_TGL`  out  1  request toggle to the destination domain.
- `ACK_TGL`  in  1  acknowledge toggle from the destination domain; asynchronous to `CLK`.

## Operation
- State machine states: `IDLE`, `LOAD`, `ARM`, `WAIT_ACK`.
- `IDLE`:
  - `RDY`=1.
  - On an accepted write: `XD`<=`D_IN`, `XEN`<=1, next state `LOAD`.
- `LOAD`:
  - `XEN`<=0.
  - Next state `ARM`.
  - `CrossingRegN` captures `XD` at this edge.
- `ARM`:
  - `REQ_TGL`<=~`REQ_TGL`.
  - Next state `WAIT_ACK`.
  - The toggle is therefore issued one full cycle after the crossing register is stable.
- `WAIT_ACK`:
  - Stay until `ack_s` == `REQ_TGL`, then go to `IDLE`.
  - `ack_s` is the last synchroniser stage.
- `XD` changes only on an accepted write (or on a coalesced launch); otherwise it holds.
- `ACK_TGL` toggling while in `IDLE`, `LOAD` or `ARM` (a protocol violation) is ignored. Only equality in `WAIT_ACK` is evaluated.
- Reset values, asserted asynchronously on `RST_N`=0:
  - state `IDLE`, `XD`=`init`, `XEN`=0, `REQ_TGL`=0, all synchroniser flops 0.
  - `RDY`=1 from the first cycle after reset release.
  - Hold register = `init` and `pend`=0 (when the `_EN` macro is compiled in).
- Reset mid-handshake abandons the transfer. The destination must be reset in the same reset domain so that `ACK_TGL` also returns to 0.

## Timing
- Accepted write at edge k:
  - `XEN`=1 during cycle k..k+1.
  - `CrossingRegN.Q_OUT` is valid after edge k+1.
  - `REQ_TGL` flips at edge k+2.
- Acknowledge path:
  - An acknowledge toggle is seen in `ack_s` `sync_stages` edges after it is sampled.
  - The exit from `WAIT_ACK` happens at the edge after that.
  - `RDY` rises in the same cycle as the exit.
- Minimum write-to-write spacing (destination acknowledges with 0 delay): 3 + `sync_stages` + 1 cycles.
- `RDY` is a combinational decode of state only. It has no dependence on `EN`.

## Configuration
- Macro: `CROSSING_REG_SRC_COALESCE_EN`.
- Defined:
  - `RDY` is held at 1 in every state.
  - A write accepted outside `IDLE` goes into a hold register and sets `pend`. A later write overwrites the hold register (last value wins).
  - On exit from `WAIT_ACK` with `pend`=1: go directly to `LOAD` with `XD`<=hold, `XEN`<=1, `pend`<=0.
  - A write in the same cycle as the `WAIT_ACK` exit takes precedence over the hold register.
- Undefined:
  - No hold register.
  - `RDY`=0 outside `IDLE`.
  - `EN` with `RDY`=0 is ignored and must not alter `XD`.

## Structure
- Shared package `crossing_pkg`:
  - state enum `xsrc_state_t` (`IDLE`, `LOAD`, `ARM`, `WAIT_ACK`).
  - constants `XSRC_SYNC_MIN`=2 and `XSRC_SYNC_MAX`=4.
- One sub-module, `sync_bit_n`:
  - `sync_stages`-deep single-bit synchroniser, async active-low reset to 0.
  - Reused by the destination-side block for `REQ_TGL`.

## Test plan
- Reset, then write `D_IN`=8'hA5 with `EN` pulsed once:
  - `XEN` high for exactly 1 cycle, with `XD`=8'hA5.
  - `REQ_TGL` 0->1 two edges after acceptance.
  - `RDY`=0 until the acknowledge.
- Destination model toggles `ACK_TGL` 5 cycles after `REQ_TGL`, with `sync_stages`=2 -> `RDY` returns exactly 3 edges after the `ACK_TGL` change.
- Without the macro, `EN` held high with `D_IN` counting 1,2,3,... -> only values seen while `RDY`=1 appear on `XD`, and `REQ_TGL` alternates once per transfer.
- With the macro, writes 8'h11, 8'h22, 8'h33 issued during `WAIT_ACK` -> after the acknowledge, the next load is 8'h33; 8'h22 is never loaded.
- `RST_N` asserted while in `WAIT_ACK`, with no clock edge -> `XEN`=0, `REQ_TGL`=0, `XD`=`init` immediately; `RDY`=1 after release.
- `ACK_TGL` toggled while in `IDLE` -> no state change and no `XEN`. The next write completes normally once `ACK_TGL` is restored to match `REQ_TGL`.

Source files
------------

// File: rtl/crossing_pkg.sv
// crossing_pkg: shared types and limits for the crossing-register source and
// destination controllers.
//   xsrc_state_t  : source-side handshake FSM states
//   XSRC_SYNC_MIN : smallest legal acknowledge synchroniser depth
//   XSRC_SYNC_MAX : largest legal acknowledge synchroniser depth
package crossing_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ARM      = 2'd2,
    WAIT_ACK = 2'd3
  } xsrc_state_t;

  localparam int XSRC_SYNC_MIN = 2;
  localparam int XSRC_SYNC_MAX = 4;

  function automatic bit xsrc_sync_ok(input int n);
    return (n >= XSRC_SYNC_MIN) && (n <= XSRC_SYNC_MAX);
  endfunction
endpackage

// File: rtl/crossing_reg_src_if.sv
// crossing_reg_src_if: write/crossing/handshake bundle of crossing_reg_src.
//   D_IN, EN      : write request from local logic
//   RDY           : write can be accepted this cycle
//   XD, XEN       : data and one-cycle load strobe to CrossingRegN
//   REQ_TGL       : request toggle to the destination domain
//   ACK_TGL       : acknowledge toggle back from the destination domain
// slave  : the source controller.
// master : its environment (local writer plus destination side).
interface crossing_reg_src_if #(
  parameter int width = 1
);
  logic [width-1:0] D_IN;
  logic             EN;
  logic             RDY;
  logic [width-1:0] XD;
  logic             XEN;
  logic             REQ_TGL;
  logic             ACK_TGL;

  modport master (output D_IN, EN, ACK_TGL, input RDY, XD, XEN, REQ_TGL);
  modport slave  (input D_IN, EN, ACK_TGL, output RDY, XD, XEN, REQ_TGL);
endinterface

// File: rtl/sync_bit_n.sv
// sync_bit_n: stages-deep single-bit synchroniser, async active-low reset to 0.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input bit
//   o_q     : synchronised bit (last stage)
module sync_bit_n #(
  parameter int stages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [stages-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[stages-2:0], i_d};
  end

  assign o_q = r_sync[stages-1];
endmodule

// File: rtl/crossing_reg_src.sv
// crossing_reg_src: source-domain controller feeding a CrossingRegN holding
// register. Loads XD/XEN for one cycle, toggles REQ_TGL one cycle later, then
// blocks until the resynchronised ACK_TGL matches REQ_TGL.
//   CLK, RST_N : source clock, asynchronous active-low reset
//   bus        : crossing_reg_src_if.slave (D_IN/EN/RDY/XD/XEN/REQ_TGL/ACK_TGL)
// Parameters: width (data width), init (reset value of XD), sync_stages (2..4).
// Optional macro CROSSING_REG_SRC_COALESCE_EN: RDY always 1; writes arriving
// while busy are coalesced into a hold register (last value wins) and launched
// straight from WAIT_ACK.
module crossing_reg_src
  import crossing_pkg::*;
#(
  parameter int               width       = 1,
  parameter logic [width-1:0] init        = '0,
  parameter int               sync_stages = 2
) (
  input logic                CLK,
  input logic                RST_N,
  crossing_reg_src_if.slave  bus
);
  if (!xsrc_sync_ok(sync_stages)) begin : g_bad_sync
    $error("crossing_reg_src: sync_stages must be within 2..4");
  end

  xsrc_state_t      r_state, w_nxt;
  logic [width-1:0] r_xd, w_xd;
  logic             r_xen, w_xen;
  logic             r_req, w_req;
  logic             w_ack_s;
  logic             w_rdy;
  logic             w_acc;

  sync_bit_n #(.stages(sync_stages)) u_ack_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_d     (bus.ACK_TGL),
    .o_q     (w_ack_s)
  );

`ifdef CROSSING_REG_SRC_COALESCE_EN
  logic [width-1:0] r_hold, w_hold;
  logic             r_pend, w_pend;
  assign w_rdy = 1'b1;
`else
  assign w_rdy = (r_state == IDLE);
`endif

  assign w_acc = bus.EN && w_rdy;

  always_comb begin
    w_nxt = r_state;
    w_xd  = r_xd;
    w_xen = 1'b0;
    w_req = r_req;
`ifdef CROSSING_REG_SRC_COALESCE_EN
    w_hold = r_hold;
    w_pend = r_pend;
`endif
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_xd  = bus.D_IN;
          w_xen = 1'b1;
          w_nxt = LOAD;
        end
      end
      LOAD: w_nxt = ARM;
      // Request is toggled only after CrossingRegN has held XD for a cycle.
      ARM: begin
        w_req = ~r_req;
        w_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack_s == r_req) begin
          w_nxt = IDLE;
`ifdef CROSSING_REG_SRC_COALESCE_EN
          // A fresh write on the exit cycle beats the held value.
          if (bus.EN) begin
            w_xd   = bus.D_IN;
            w_xen  = 1'b1;
            w_pend = 1'b0;
            w_nxt  = LOAD;
          end else if (r_pend) begin
            w_xd   = r_hold;
            w_xen  = 1'b1;
            w_pend = 1'b0;
            w_nxt  = LOAD;
          end
`endif
        end
      end
      default: w_nxt = IDLE;
    endcase
`ifdef CROSSING_REG_SRC_COALESCE_EN
    // Any write not launched directly this cycle lands in the hold register.
    if (bus.EN && !w_xen) begin
      w_hold = bus.D_IN;
      w_pend = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_xd    <= init;
      r_xen   <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_xd    <= w_xd;
      r_xen   <= w_xen;
      r_req   <= w_req;
    end
  end

`ifdef CROSSING_REG_SRC_COALESCE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold <= init;
      r_pend <= 1'b0;
    end else begin
      r_hold <= w_hold;
      r_pend <= w_pend;
    end
  end
`endif

  assign bus.RDY     = w_rdy;
  assign bus.XD      = r_xd;
  assign bus.XEN     = r_xen;
  assign bus.REQ_TGL = r_req;
endmodule
